// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES inverse cipher, one round per clock, runtime-loaded
// round-key file (NR+1 entries) and optional CBC chaining.
module aes_dec_iter #(
    parameter int NR     = 10,
    parameter int CBC_EN = 0,
    parameter int KA_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_wr_en_i,
    input  logic [KA_W-1:0] key_wr_addr_i,
    input  logic [127:0]    key_wr_data_i,
    input  logic            iv_load_i,
    input  logic [127:0]    iv_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [127:0]    in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [127:0]    out_data_o,
    output logic            busy_o
);
    localparam bit CBC = CBC_EN != 0;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: inverse affine map, then GF(2^8) inverse as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a, sq, r;
        a  = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        sq = gmul(a, a);
        r  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [127:0] unshift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] byte_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                      ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        return o;
    endfunction

    state_e          fsm_q, fsm_d;
    logic [127:0]    st_q, st_d, out_q, out_d, chain_q, chain_d, hold_q, hold_d;
    logic [KA_W-1:0] cnt_q, cnt_d;
    logic [127:0]    key_q [NR+1];
    logic [127:0]    sub_w;
    logic            idle_w, key_we_w;

    assign idle_w      = fsm_q == IDLE;
    assign key_we_w    = key_wr_en_i && idle_w && (32'(key_wr_addr_i) <= NR);
    assign in_ready_o  = rst_n && idle_w;
    assign out_valid_o = fsm_q == DONE;
    assign busy_o      = !idle_w;
    assign out_data_o  = out_q;
    // InvShiftRows/InvSubBytes are shared by the middle rounds and the final round.
    assign sub_w       = byte_sub(unshift_rows(st_q));

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        hold_d  = hold_q;
        chain_d = (CBC && idle_w && iv_load_i) ? iv_i : chain_q;
        case (fsm_q)
            IDLE: if (in_valid_i) begin
                st_d   = round_key(in_data_i, key_q[NR]);
                cnt_d  = KA_W'(NR - 1);
                hold_d = in_data_i;
                fsm_d  = ROUND;
            end
            ROUND: begin
                st_d  = inv_mix(round_key(sub_w, key_q[cnt_q]));
                cnt_d = cnt_q - KA_W'(1);
                fsm_d = (cnt_q == KA_W'(1)) ? FINAL : ROUND;
            end
            FINAL: begin
                out_d   = round_key(sub_w, key_q[0]) ^ (CBC ? chain_q : 128'h0);
                chain_d = CBC ? hold_q : chain_q;
                fsm_d   = DONE;
            end
            default: fsm_d = out_ready_i ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            out_q   <= '0;
            chain_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            out_q   <= out_d;
            chain_q <= chain_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // The key file survives reset.
    always_ff @(posedge clk) begin
        if (key_we_w) key_q[key_wr_addr_i] <= key_wr_data_i;
    end
endmodule

// File: tb/tb_aes_dec_iter.sv
// tb_aes_dec_iter: AES-128 ECB, AES-256 ECB and AES-128 CBC instances checked
// against a forward-cipher model; expected plaintexts flow through a queue.
module tb_aes_dec_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [2:0]   key_wr_en = '0;
    logic [2:0]   in_valid = '0;
    logic [3:0]   key_wr_addr = '0;
    logic [127:0] key_wr_data = '0;
    logic [127:0] iv = '0;
    logic [127:0] in_data = '0;
    logic         iv_load = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready [3];
    logic         out_valid [3];
    logic         busy [3];
    logic [127:0] out_data [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_dec_iter #(.NR(g == 1 ? 14 : 10), .CBC_EN(g == 2 ? 1 : 0), .KA_W(4)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_wr_en_i  (key_wr_en[g]),
            .key_wr_addr_i(key_wr_addr),
            .key_wr_data_i(key_wr_data),
            .iv_load_i    (iv_load),
            .iv_i         (iv),
            .in_valid_i   (in_valid[g]),
            .in_ready_o   (in_ready[g]),
            .in_data_i    (in_data),
            .out_valid_o  (out_valid[g]),
            .out_ready_i  (out_ready),
            .out_data_o   (out_data[g]),
            .busy_o       (busy[g])
        );
    end

    typedef struct packed {
        logic [1:0]   idx;
        logic [127:0] d;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           last_acc = 0;
    logic [7:0]   sb [256];
    logic [127:0] ks [15];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Forward S-box from the generator-3 walk of GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            q = q[7] ? q ^ 8'h09 : q;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    task automatic expand(input logic [255:0] key, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] subsh(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mixc(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            {a0, a1, a2, a3} = col;
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ ks[0];
        for (int r = 1; r < nr; r++) s = mixc(subsh(s)) ^ ks[r];
        return subsh(s) ^ ks[nr];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input int k, input int nr);
        key_wr_en[k] = 1'b1;
        for (int a = 0; a <= nr; a++) begin
            key_wr_addr = 4'(a);
            key_wr_data = ks[a];
            tick();
        end
        key_wr_en[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [127:0] ct, input logic [127:0] pt);
        int n;
        n = 0;
        in_data = ct;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout dut=%0d got=in_ready_low want=in_ready_high", k);
        end
        exp_q.push_back({2'(k), pt});
        tick();
        in_valid[k] = 1'b0;
        last_acc = cyc;
    endtask

    // lat counts the accept cycle as cycle 1.
    task automatic wait_out(input int k, output int lat);
        lat = 1;
        while (!out_valid[k] && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            if (rst_n && out_valid[k] && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected dut=%0d got=%h want=none", k, out_data[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.idx !== 2'(k) || out_data[k] !== mon_e.d) begin
                        n_err++;
                        $display("FAIL out_data dut=%0d got=%h want=%h (dut %0d)", k, out_data[k], mon_e.d, mon_e.idx);
                    end
                end
            end
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({in_ready[k], out_valid[k], busy[k]} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_hold dut=%0d got=%b want=000", k, {in_ready[k], out_valid[k], busy[k]});
            end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({in_ready[k], out_valid[k], busy[k]} !== 3'b100) begin
                n_err++;
                $display("FAIL reset_release dut=%0d got=%b want=100", k, {in_ready[k], out_valid[k], busy[k]});
            end
            n_cmp++;
            if (out_data[k] !== 128'h0) begin
                n_err++;
                $display("FAIL reset_out_data dut=%0d got=%h want=0", k, out_data[k]);
            end
        end
    endtask

    task automatic test_fips(input int k, input logic [127:0] ct, input int want_lat);
        int lat;
        send(k, ct, 128'h00112233445566778899aabbccddeeff);
        wait_out(k, lat);
        n_cmp++;
        if (lat !== want_lat) begin
            n_err++;
            $display("FAIL latency dut=%0d got=%0d want=%0d", k, lat, want_lat);
        end
        tick();
        n_cmp++;
        if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
            n_err++;
            $display("FAIL handshake_idle dut=%0d got=%b%b want=10", k, in_ready[k], out_valid[k]);
        end
    endtask

    task automatic test_cbc();
        logic [127:0] p1, p2, p3, c1, c2, c3, iv2;
        int           lat;
        p1 = rnd128(); p2 = rnd128(); p3 = rnd128(); iv2 = rnd128();
        c1 = enc(p1 ^ 128'h000102030405060708090a0b0c0d0e0f, 10);
        c2 = enc(p2 ^ c1, 10);
        c3 = enc(p3 ^ iv2, 10);
        iv = 128'h000102030405060708090a0b0c0d0e0f;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        send(2, c1, p1);
        wait_out(2, lat);
        tick();
        n_cmp++;
        if (g_dut[2].u_dut.chain_q !== c1) begin
            n_err++;
            $display("FAIL cbc_chain got=%h want=%h", g_dut[2].u_dut.chain_q, c1);
        end
        send(2, c2, p2);
        wait_out(2, lat);
        n_cmp++;
        if (lat !== 11) begin
            n_err++;
            $display("FAIL cbc_latency got=%0d want=11", lat);
        end
        tick();
        iv = iv2;
        iv_load = 1'b1;
        send(2, c3, p3);
        iv_load = 1'b0;
        wait_out(2, lat);
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] p;
        int           lat;
        p = rnd128();
        out_ready = 1'b0;
        send(0, enc(p, 10), p);
        wait_out(0, lat);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (out_data[0] !== p || {in_ready[0], busy[0], out_valid[0]} !== 3'b011) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d got=%h/%b want=%h/011", i, out_data[0],
                         {in_ready[0], busy[0], out_valid[0]}, p);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if ({in_ready[0], busy[0], out_valid[0]} !== 3'b100) begin
            n_err++;
            $display("FAIL bp_release got=%b want=100", {in_ready[0], busy[0], out_valid[0]});
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] p;
        int           prev, lat;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            p = rnd128();
            send(0, enc(p, 10), p);
            if (i > 0) begin
                n_cmp++;
                if (last_acc - prev !== 12) begin
                    n_err++;
                    $display("FAIL throughput got=%0d want=12", last_acc - prev);
                end
            end
            prev = last_acc;
        end
        wait_out(0, lat);
        tick();
    endtask

    task automatic test_keywr();
        logic [127:0] p, delta;
        int           lat;
        delta = rnd128();
        p = rnd128();
        send(0, enc(p, 10), p);
        repeat (3) tick();
        key_wr_en[0] = 1'b1;
        key_wr_addr = 4'd10;
        key_wr_data = ks[10] ^ delta;
        tick();
        key_wr_addr = 4'd0;
        key_wr_data = rnd128();
        tick();
        key_wr_en[0] = 1'b0;
        wait_out(0, lat);
        tick();
        // write and accept on the same edge: block uses the old last-round key
        p = rnd128();
        key_wr_en[0] = 1'b1;
        key_wr_addr = 4'd10;
        key_wr_data = ks[10] ^ delta;
        send(0, enc(p, 10), p);
        key_wr_en[0] = 1'b0;
        wait_out(0, lat);
        tick();
        p = rnd128();
        send(0, enc(p, 10) ^ delta, p);
        wait_out(0, lat);
        tick();
        key_wr_en[0] = 1'b1;
        key_wr_data = rnd128();
        for (int a = 11; a < 16; a++) begin
            key_wr_addr = 4'(a);
            tick();
        end
        key_wr_addr = 4'd10;
        key_wr_data = ks[10];
        tick();
        key_wr_en[0] = 1'b0;
        p = rnd128();
        send(0, enc(p, 10), p);
        wait_out(0, lat);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] p;
        int           lat;
        p = rnd128();
        send(0, enc(p, 10), p);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got=%b%b want=00", out_valid[0], in_ready[0]);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_release got=%b%b want=10", in_ready[0], busy[0]);
        end
        p = rnd128();
        send(0, enc(p, 10), p);
        wait_out(0, lat);
        n_cmp++;
        if (lat !== 11) begin
            n_err++;
            $display("FAIL reset_mid_latency got=%0d want=11", lat);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
        load_keys(1, 14);
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
        load_keys(0, 10);
        load_keys(2, 10);
        test_fips(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11);
        test_fips(1, 128'h8ea2b7ca516745bfeafc49904b496089, 15);
        test_cbc();
        test_backpressure();
        test_back_to_back();
        test_keywr();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL pending_outputs got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
